// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and receiver:
// frame constants, transmitter state encoding, baud divisor and parity.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_ACK    = 3'd5
  } tx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // odd = 1'b1 makes the total count of ones (data + parity) odd
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// Held at zero while i_restart is high so a new frame always starts on a clean period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 19_200
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrap exactly at LAST so every bit lasts DIV cycles with no drift
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_restart) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (r_cnt == LAST) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per send/sent handshake, start + 8 data (LSB first) + stop.
// Define UART_TX_PARITY_EN to insert a parity bit (odd/even by PARITY_ODD) before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 19_200,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       sent,
  output logic       busy,
  output logic       tx_out
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic             w_tick;
  logic             w_restart;
  logic             w_tx_next;
  logic             w_busy_next;
  logic             w_sent_next;
  logic             r_tx;
  logic             r_busy;
  logic             r_sent;
`ifdef UART_TX_PARITY_EN
  logic [7:0]       r_data;
`else
  if (PARITY_ODD) begin : g_parity_odd_has_no_effect
  end
`endif

  // Counter is parked outside the frame so START always gets a full period
  assign w_restart = (r_state == TX_IDLE) || (r_state == TX_ACK);

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TX_IDLE: begin
        if (send) w_state_next = TX_START;
        else      w_state_next = TX_IDLE;
      end
      TX_START: begin
        if (w_tick) w_state_next = TX_DATA;
        else        w_state_next = TX_START;
      end
      TX_DATA: begin
        if (w_tick && (r_bit == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = TX_PARITY;
`else
          w_state_next = TX_STOP;
`endif
        end else begin
          w_state_next = TX_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (w_tick) w_state_next = TX_STOP;
        else        w_state_next = TX_PARITY;
      end
`endif
      TX_STOP: begin
        if (w_tick) w_state_next = TX_ACK;
        else        w_state_next = TX_STOP;
      end
      TX_ACK: begin
        if (!send) w_state_next = TX_IDLE;
        else       w_state_next = TX_ACK;
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  // Shift register and bit index advance together on each data-bit boundary
  always_comb begin
    if ((r_state == TX_DATA) && w_tick) begin
      w_shift_next = {1'b0, r_shift[7:1]};
      w_bit_next   = (r_bit == LAST_BIT) ? 3'd0 : (r_bit + 3'd1);
    end else begin
      w_shift_next = r_shift;
      w_bit_next   = r_bit;
    end
  end

  // Datapath registers; din is captured only when a frame is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= 8'h00;
      r_bit   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      r_data  <= 8'h00;
`endif
    end else if ((r_state == TX_IDLE) && send) begin
      r_shift <= din;
      r_bit   <= 3'd0;
`ifdef UART_TX_PARITY_EN
      r_data  <= din;
`endif
    end else begin
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
    end
  end

  // Output decode from the next state so the line changes on the same edge as the state
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = 1'b0;
    w_sent_next = 1'b0;
    case (w_state_next)
      TX_IDLE: begin
        w_tx_next = 1'b1;
      end
      TX_START: begin
        w_tx_next   = START_BIT;
        w_busy_next = 1'b1;
      end
      TX_DATA: begin
        w_tx_next   = w_shift_next[0];
        w_busy_next = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        w_tx_next   = parity_bit(r_data, PARITY_ODD);
        w_busy_next = 1'b1;
      end
`endif
      TX_STOP: begin
        w_tx_next   = STOP_BIT;
        w_busy_next = 1'b1;
      end
      TX_ACK: begin
        w_tx_next   = 1'b1;
        w_sent_next = 1'b1;
      end
      default: begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        w_sent_next = 1'b0;
      end
    endcase
  end

  // Registered outputs keep tx_out glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_sent <= 1'b0;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      r_sent <= w_sent_next;
    end
  end

  assign tx_out = r_tx;
  assign busy   = r_busy;
  assign sent   = r_sent;

endmodule
